// File: rtl/func_hdl_pkg.sv
// Shared constants and the element add for the func_hdl_top_add2 kernel.
// Optional build macro FUNC_HDL_SAT_EN selects an unsigned saturating add.
package func_hdl_pkg;

    localparam int C_DATA_WIDTH   = 32;
    localparam int C_NUM_CHANNELS = 2;
    localparam int C_OFIFO_DEPTH  = 3;
    localparam int C_LATENCY      = 2;
    localparam int VIN0           = 0;
    localparam int VIN1           = 1;
    localparam int C_CNT_W        = $clog2(C_OFIFO_DEPTH + 1);

    typedef logic [C_DATA_WIDTH-1:0] data_t;

    function automatic data_t add2(input data_t a, input data_t b);
        logic [C_DATA_WIDTH:0] full;
        full = {1'b0, a} + {1'b0, b};
`ifdef FUNC_HDL_SAT_EN
        add2 = full[C_DATA_WIDTH] ? {C_DATA_WIDTH{1'b1}} : full[C_DATA_WIDTH-1:0];
`else
        add2 = full[C_DATA_WIDTH-1:0];
`endif
    endfunction

endpackage

// File: rtl/func_hdl_top_add2_fifo.sv
// axis_out_fifo: small shift-style FIFO whose head entry is a register driving the output.
module axis_out_fifo
    import func_hdl_pkg::*;
#(
    parameter int DEPTH = C_OFIFO_DEPTH,
    parameter int W     = C_DATA_WIDTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [CW-1:0] count_o,
    output logic [W-1:0]  head_o
);

    logic [W-1:0]  mem_q   [DEPTH];
    logic [W-1:0]  mem_d   [DEPTH];
    logic [W-1:0]  shift_s [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] wr_idx_s;

    // Next-state storage: entry 0 is always the head; a pop shifts everything down by one.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_s[i] = pop_i ? mem_q[i+1] : mem_q[i];
        end
        shift_s[DEPTH-1] = pop_i ? {W{1'b0}} : mem_q[DEPTH-1];
        wr_idx_s = pop_i ? (count_q - {{(CW-1){1'b0}}, 1'b1}) : count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push_i && (wr_idx_s == CW'(i))) ? push_data_i : shift_s[i];
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Storage and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/func_hdl_top_add2.sv
// Two-channel stream join feeding a registered adder and an output skid FIFO.
// Build option FUNC_HDL_SAT_EN (see func_hdl_pkg) makes the add saturate.
module func_hdl_top_add2
    import func_hdl_pkg::*;
(
    input  logic                                   aclk,
    input  logic                                   areset_n,
    input  logic [C_NUM_CHANNELS-1:0]              s_tvalid,
    input  logic [C_DATA_WIDTH*C_NUM_CHANNELS-1:0] s_tdata,
    output logic [C_NUM_CHANNELS-1:0]              s_tready,
    output logic                                   m_tvalid,
    output logic [C_DATA_WIDTH-1:0]                m_tdata,
    input  logic                                   m_tready
);

    logic                    v1_q;
    logic                    v1_d;
    data_t                   sum1_q;
    data_t                   sum1_d;
    data_t                   vin0_s;
    data_t                   vin1_s;
    logic [C_CNT_W-1:0]      fifo_count_s;
    data_t                   fifo_head_s;
    logic [C_CNT_W:0]        occ_s;
    logic                    space_s;
    logic                    all_valid_s;
    logic                    fire_s;
    logic                    pop_s;

    assign vin0_s = s_tdata[VIN0*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign vin1_s = s_tdata[VIN1*C_DATA_WIDTH +: C_DATA_WIDTH];

    // Room is judged from registered occupancy only, so m_tready never reaches s_tready.
    assign occ_s       = {1'b0, fifo_count_s} + {{C_CNT_W{1'b0}}, v1_q};
    assign space_s     = (occ_s <= (C_CNT_W + 1)'(C_OFIFO_DEPTH - 1));
    assign all_valid_s = &s_tvalid;
    assign fire_s      = space_s & all_valid_s & areset_n;
    assign s_tready    = {C_NUM_CHANNELS{fire_s}};

    assign m_tvalid = (fifo_count_s != {C_CNT_W{1'b0}});
    assign m_tdata  = fifo_head_s;
    assign pop_s    = m_tvalid & m_tready;

    // Stage-1 next state: load on a joined handshake, otherwise drain into the FIFO.
    always_comb begin
        v1_d   = v1_q;
        sum1_d = sum1_q;
        if (fire_s) begin
            sum1_d = add2(vin0_s, vin1_s);
            v1_d   = 1'b1;
        end else if (v1_q) begin
            v1_d = 1'b0;
        end else begin
            v1_d = v1_q;
        end
    end

    // Stage-1 compute register with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            v1_q   <= 1'b0;
            sum1_q <= {C_DATA_WIDTH{1'b0}};
        end else begin
            v1_q   <= v1_d;
            sum1_q <= sum1_d;
        end
    end

    axis_out_fifo #(
        .DEPTH (C_OFIFO_DEPTH),
        .W     (C_DATA_WIDTH),
        .CW    (C_CNT_W)
    ) u_ofifo (
        .clk_i       (aclk),
        .rst_n_i     (areset_n),
        .push_i      (v1_q),
        .push_data_i (sum1_q),
        .pop_i       (pop_s),
        .count_o     (fifo_count_s),
        .head_o      (fifo_head_s)
    );

endmodule

// File: tb/tb_func_hdl_top_add2.sv
// Directed scoreboard bench for func_hdl_top_add2 (honours FUNC_HDL_SAT_EN when defined).
module tb_func_hdl_top_add2;
    import func_hdl_pkg::*;

    logic        aclk = 1'b0;
    logic        areset_n;
    logic [1:0]  s_tvalid;
    logic [63:0] s_tdata;
    logic [1:0]  s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tready;

    func_hdl_top_add2 dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tready (m_tready)
    );

    always #5 aclk = ~aclk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          first_val_cyc = -1;
    int          last_out_cyc = -1;
    logic [31:0] exp_q[$];
    logic        in_fire, out_fire;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic [31:0] last_out_data;
    logic [1:0]  smp_s_tready;
    logic        smp_m_tvalid;
    logic [31:0] smp_m_tdata;

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef FUNC_HDL_SAT_EN
        if (s[32]) return 32'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score handshakes, then step past the rising edge.
    task automatic tick();
        @(negedge aclk);
        smp_s_tready = s_tready;
        smp_m_tvalid = m_tvalid;
        smp_m_tdata  = m_tdata;
        in_fire  = areset_n && (&s_tvalid) && (&s_tready);
        out_fire = m_tvalid && m_tready;
        if (hold_pend && areset_n) begin
            check("hold_m_tvalid", 32'(m_tvalid), 32'd1);
            check("hold_m_tdata", m_tdata, hold_data);
        end
        hold_pend = m_tvalid && !m_tready && areset_n;
        hold_data = m_tdata;
        if (m_tvalid === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
        if (out_fire) begin
            if (exp_q.size() == 0) check("output_without_input", 32'(exp_q.size()), 32'd1);
            else check("vout", m_tdata, exp_q.pop_front());
            n_out++;
            last_out_cyc  = cyc;
            last_out_data = m_tdata;
        end
        if (in_fire) exp_q.push_back(model_add(s_tdata[31:0], s_tdata[63:32]));
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    // mode 0: ready always; 1: ready low 1 of 4 cycles; 2: ready low for a 4-cycle window.
    task automatic run_stream(input int n, input int mode);
        int idx = 0;
        int lc = 0;
        int out0;
        int acc_first = -1;
        int acc_last = -1;
        int stall_acc = 0;
        out0 = n_out;
        first_val_cyc = -1;
        while ((idx < n || (n_out - out0) < n) && lc < 8 * n + 64) begin
            s_tvalid = (idx < n) ? 2'b11 : 2'b00;
            s_tdata  = {32'(idx + 1), 32'(idx + 1)};
            case (mode)
                1:       m_tready = (lc % 4 != 3);
                2:       m_tready = !(lc >= 10 && lc < 14);
                default: m_tready = 1'b1;
            endcase
            tick();
            if (mode == 2 && lc >= 11 && lc < 14) check("s_tready_after_stall", 32'(smp_s_tready), 32'd0);
            if (in_fire) begin
                if (acc_first < 0) acc_first = cyc - 1;
                acc_last = cyc - 1;
                if (mode == 2 && lc >= 10 && lc < 14) stall_acc++;
                idx++;
            end
            lc++;
        end
        s_tvalid = 2'b00;
        check("stream_inputs", 32'(idx), 32'(n));
        check("stream_outputs", 32'(n_out - out0), 32'(n));
        if (mode == 0) begin
            check("first_valid_latency", 32'(first_val_cyc - acc_first), 32'(C_LATENCY));
            check("inputs_consecutive", 32'(acc_last - acc_first), 32'(n - 1));
            check("outputs_consecutive", 32'(last_out_cyc - first_val_cyc), 32'(n - 1));
        end
        if (mode == 2) check("accepts_during_stall", 32'(stall_acc), 32'd1);
    endtask

    initial begin
        int out0;
        areset_n = 1'b0;
        s_tvalid = 2'b11;
        s_tdata  = 64'h0000_0001_0000_0001;
        m_tready = 1'b1;
        tick();
        tick();
        check("reset_m_tvalid", 32'(smp_m_tvalid), 32'd0);
        check("reset_m_tdata", smp_m_tdata, 32'd0);
        check("reset_s_tready", 32'(smp_s_tready), 32'd0);
        s_tvalid = 2'b00;
        areset_n = 1'b1;
        tick();

        run_stream(1024, 0);
        run_stream(1024, 1);
        run_stream(32, 2);

        m_tready = 1'b1;
        s_tvalid = 2'b01;
        s_tdata  = {32'h1111_1111, 32'h0000_1234};
        for (int i = 0; i < 5; i++) begin
            tick();
            check("partial_s_tready", 32'(smp_s_tready), 32'd0);
        end
        out0 = n_out;
        s_tvalid = 2'b11;
        tick();
        check("join_accept", 32'(in_fire), 32'd1);
        s_tvalid = 2'b00;
        for (int i = 0; i < 6; i++) tick();
        check("join_one_result", 32'(n_out - out0), 32'd1);
        check("join_value", last_out_data, 32'h1111_2345);

        s_tvalid = 2'b11;
        s_tdata  = {32'h0000_0001, 32'hFFFF_FFFF};
        tick();
        check("ovf_accept", 32'(in_fire), 32'd1);
        s_tvalid = 2'b00;
        for (int i = 0; i < 4; i++) tick();
`ifdef FUNC_HDL_SAT_EN
        check("ovf_value", last_out_data, 32'hFFFF_FFFF);
`else
        check("ovf_value", last_out_data, 32'h0000_0000);
`endif

        m_tready = 1'b0;
        s_tvalid = 2'b11;
        s_tdata  = {32'd5, 32'd5};
        tick();
        s_tdata  = {32'd6, 32'd6};
        tick();
        s_tvalid = 2'b00;
        tick();
        tick();
        check("pending_before_reset", 32'(exp_q.size()), 32'd2);
        areset_n = 1'b0;
        s_tvalid = 2'b11;
        tick();
        tick();
        check("midreset_m_tvalid", 32'(smp_m_tvalid), 32'd0);
        check("midreset_m_tdata", smp_m_tdata, 32'd0);
        check("midreset_s_tready", 32'(smp_s_tready), 32'd0);
        exp_q.delete();
        s_tvalid = 2'b00;
        areset_n = 1'b1;
        m_tready = 1'b1;
        tick();
        run_stream(16, 0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
